// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter
// Two-master arbiter for the memory-mapped peripheral bus (timer, LED, digit,
// systick and selreg registers). Master 0 is the CPU data port, master 1 a
// secondary bus master such as a DMA/loader engine.
//
// Grant policy: round-robin tie-break in IDLE with a per-burst cycle limit
// (BURST_MAX, 0 = unlimited) that forces a handover when the other master is
// waiting. Bus steering, acks and read data are combinational from the
// registered grant state, so an asserted reset removes all strobes at once.
//
// Build option: define PERIPH_ARB_FIXED_PRIO_EN to give master 0 fixed
// priority (ties go to master 0, master 0 is never preempted; the burst limit
// only preempts master 1).

module periph_bus_arbiter #(
    parameter int BURST_MAX = 16,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_rd,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_rd,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_rd,
    output logic              s_wr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              owner,
    output logic              busy
);

    // Burst counter is wide enough to hold BURST_MAX-1; one bit when unlimited.
    localparam int CNT_W = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
    localparam bit LIMIT_EN = (BURST_MAX != 0);
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        (BURST_MAX == 0) ? {CNT_W{1'b0}} : CNT_W'(BURST_MAX - 1);

`ifdef PERIPH_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_G0   = 2'd1;
    localparam logic [1:0] ST_G1   = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] burst_cnt_r;
    logic             last_r;
    logic             limit_hit_s;

    // Next grant state: request, release, round-robin tie and burst-limit handover.
    always_comb begin
        state_nxt_s = state_r;
        limit_hit_s = LIMIT_EN && (burst_cnt_r == CNT_LIMIT);
        case (state_r)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
                    // last_r = 1 means master 1 owned last, so master 0 wins.
                    if (FIXED_PRIO || last_r) begin
                        state_nxt_s = ST_G0;
                    end else begin
                        state_nxt_s = ST_G1;
                    end
                end else if (m0_req) begin
                    state_nxt_s = ST_G0;
                end else if (m1_req) begin
                    state_nxt_s = ST_G1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_G0: begin
                if (!m0_req) begin
                    state_nxt_s = m1_req ? ST_G1 : ST_IDLE;
                end else if (m1_req && limit_hit_s && !FIXED_PRIO) begin
                    state_nxt_s = ST_G1;
                end else begin
                    state_nxt_s = ST_G0;
                end
            end
            ST_G1: begin
                if (!m1_req) begin
                    state_nxt_s = m0_req ? ST_G0 : ST_IDLE;
                end else if (m0_req && limit_hit_s) begin
                    state_nxt_s = ST_G0;
                end else begin
                    state_nxt_s = ST_G1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Grant state, burst counter, last owner and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            burst_cnt_r <= {CNT_W{1'b0}};
            last_r      <= 1'b1;
            m0_gnt      <= 1'b0;
            m1_gnt      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_nxt_s != state_r) || (state_nxt_s == ST_IDLE)) begin
                burst_cnt_r <= {CNT_W{1'b0}};
            end else if (LIMIT_EN && (burst_cnt_r != CNT_LIMIT)) begin
                burst_cnt_r <= burst_cnt_r + CNT_W'(1);
            end else begin
                burst_cnt_r <= burst_cnt_r;
            end
            if ((state_nxt_s == ST_G0) && (state_r != ST_G0)) begin
                last_r <= 1'b0;
            end else if ((state_nxt_s == ST_G1) && (state_r != ST_G1)) begin
                last_r <= 1'b1;
            end else begin
                last_r <= last_r;
            end
            m0_gnt <= (state_nxt_s == ST_G0);
            m1_gnt <= (state_nxt_s == ST_G1);
            busy   <= (state_nxt_s != ST_IDLE);
        end
    end

    assign owner = last_r;

    // Steer the owning master's access onto the peripheral bus; IDLE drives zeros.
    always_comb begin
        s_rd    = 1'b0;
        s_wr    = 1'b0;
        s_addr  = {ADDR_W{1'b0}};
        s_wdata = {DATA_W{1'b0}};
        case (state_r)
            ST_G0: begin
                s_rd    = m0_rd & m0_req;
                s_wr    = m0_wr & m0_req;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
            end
            ST_G1: begin
                s_rd    = m1_rd & m1_req;
                s_wr    = m1_wr & m1_req;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
            end
            default: begin
                s_rd    = 1'b0;
                s_wr    = 1'b0;
                s_addr  = {ADDR_W{1'b0}};
                s_wdata = {DATA_W{1'b0}};
            end
        endcase
    end

    // Completion and read data go to the owner only.
    assign m0_ack   = m0_gnt & m0_req & (m0_rd | m0_wr);
    assign m1_ack   = m1_gnt & m1_req & (m1_rd | m1_wr);
    assign m0_rdata = (m0_gnt & m0_rd) ? s_rdata : {DATA_W{1'b0}};
    assign m1_rdata = (m1_gnt & m1_rd) ? s_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter with BURST_MAX = 4: directed scenarios with
// literal expectations, then randomized traffic checked every cycle against a
// cycle-level ownership model. Honours PERIPH_ARB_FIXED_PRIO_EN if defined.

module tb_periph_bus_arbiter;

    localparam int BMAX = 4;
`ifdef PERIPH_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 1'b0, m0_rd = 1'b0, m0_wr = 1'b0;
    logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0;
    logic        m1_req = 1'b0, m1_rd = 1'b0, m1_wr = 1'b0;
    logic [31:0] m1_addr = 32'h0, m1_wdata = 32'h0;
    logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_rd, s_wr;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        owner, busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    periph_bus_arbiter #(.BURST_MAX(BMAX), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .s_rd(s_rd), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    // Peripheral register file: eight words, combinational read, write on clock.
    logic [31:0] periph [0:7];
    assign s_rdata = periph[s_addr[4:2]];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) periph[i] <= 32'hA000_0000 + 32'(i);
        end else if (s_wr) begin
            periph[s_addr[4:2]] <= s_wdata;
        end
    end

    // Ownership model: 0 / 1 = master owns the bus, 2 = nobody.
    int own_m = 2;   // owner during the current cycle
    int run_m = 0;   // cycles the current owner has held the bus so far
    int last_m = 1;  // most recent owner

    function automatic int f_next(int own, int run, int lst, logic r0, logic r1);
        logic own_req, oth_req;
        if (own == 2) begin
            if (r0 && r1) return FIXED ? 0 : 1 - lst;
            if (r0) return 0;
            if (r1) return 1;
            return 2;
        end
        own_req = (own == 0) ? r0 : r1;
        oth_req = (own == 0) ? r1 : r0;
        if (!own_req) return oth_req ? 1 - own : 2;
        if (oth_req && BMAX > 0 && run >= BMAX && !(FIXED && own == 0)) return 1 - own;
        return own;
    endfunction

    function automatic int f_run(int own, int run, int lst, logic r0, logic r1);
        int nx;
        nx = f_next(own, run, lst, r0, r1);
        if (nx == 2) return 0;
        if (nx == own) return run + 1;
        return 1;
    endfunction

    // Advance the model once per clock; reset forces it back to nobody/last=1.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            own_m  <= 2;
            run_m  <= 0;
            last_m <= 1;
        end else begin
            own_m  <= f_next(own_m, run_m, last_m, m0_req, m1_req);
            run_m  <= f_run(own_m, run_m, last_m, m0_req, m1_req);
            last_m <= (f_next(own_m, run_m, last_m, m0_req, m1_req) == 2) ? last_m :
                      f_next(own_m, run_m, last_m, m0_req, m1_req);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m0_gnt", m0_gnt, own_m == 0);
            chk("m1_gnt", m1_gnt, own_m == 1);
            chk("busy", busy, own_m != 2);
            chk("owner", owner, last_m[0]);
            chk("s_rd", s_rd, (own_m == 0) ? (m0_rd & m0_req) : (own_m == 1) ? (m1_rd & m1_req) : 1'b0);
            chk("s_wr", s_wr, (own_m == 0) ? (m0_wr & m0_req) : (own_m == 1) ? (m1_wr & m1_req) : 1'b0);
            chk("s_addr", s_addr, (own_m == 0) ? m0_addr : (own_m == 1) ? m1_addr : 32'h0);
            chk("s_wdata", s_wdata, (own_m == 0) ? m0_wdata : (own_m == 1) ? m1_wdata : 32'h0);
            chk("m0_ack", m0_ack, (own_m == 0) && m0_req && (m0_rd || m0_wr));
            chk("m1_ack", m1_ack, (own_m == 1) && m1_req && (m1_rd || m1_wr));
            chk("m0_rdata", m0_rdata, (own_m == 0 && m0_rd) ? periph[m0_addr[4:2]] : 32'h0);
            chk("m1_rdata", m1_rdata, (own_m == 1 && m1_rd) ? periph[m1_addr[4:2]] : 32'h0);
            chk("one_grant", m0_gnt & m1_gnt, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_rd = 1'b0; m0_wr = 1'b0;
        m1_req = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b1;
        cmp_en = 1'b1;

        // Reset state
        mid();
        chk("rst_m0_gnt", m0_gnt, 1'b0);
        chk("rst_m1_gnt", m1_gnt, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 1'b1);
        chk("rst_s_wr", s_wr, 1'b0);

        // Single master write to TH: grant, ack and strobe one cycle after req
        tick();
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 32'h4000_0000; m0_wdata = 32'h0000_1234;
        mid();
        chk("wr_req_cycle_gnt", m0_gnt, 1'b0);
        tick();
        mid();
        chk("wr_m0_gnt", m0_gnt, 1'b1);
        chk("wr_m0_ack", m0_ack, 1'b1);
        chk("wr_s_wr", s_wr, 1'b1);
        chk("wr_m1_gnt", m1_gnt, 1'b0);
        tick();
        chk("wr_th_value", periph[0], 32'h0000_1234);
        idle_inputs();
        tick();

        // Tie right after reset, then burst-limit alternation
        do_reset();
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            mid();
            chk($sformatf("tie_m0_gnt_%0d", i), m0_gnt, FIXED ? 1'b1 : (((i / BMAX) % 2) == 0));
            chk($sformatf("tie_m1_gnt_%0d", i), m1_gnt, FIXED ? 1'b0 : (((i / BMAX) % 2) == 1));
            tick();
        end
        idle_inputs();
        tick();

        // Simultaneous owner release and other request: direct handover
        m0_req = 1'b1;
        tick();
        m0_req = 1'b0; m1_req = 1'b1;
        mid();
        chk("ho_m0_gnt_before", m0_gnt, 1'b1);
        tick();
        mid();
        chk("ho_m1_gnt_after", m1_gnt, 1'b1);
        chk("ho_m0_gnt_after", m0_gnt, 1'b0);
        chk("ho_busy", busy, 1'b1);
        tick();
        m1_req = 1'b0;
        tick();
        // Next tie after master 1 owned: master 0 wins
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        mid();
        chk("rr_tie2_m0_gnt", m0_gnt, 1'b1);
        chk("rr_tie2_m1_gnt", m1_gnt, 1'b0);
        tick();
        idle_inputs();
        tick();
        tick();

        // Read path to systick through master 1; master 0 strobes ignored
        m1_req = 1'b1; m1_rd = 1'b1; m1_addr = 32'h4000_0014;
        m0_rd = 1'b1; m0_addr = 32'h4000_0000;
        tick();
        mid();
        chk("rd_m1_gnt", m1_gnt, 1'b1);
        chk("rd_m1_ack", m1_ack, 1'b1);
        chk("rd_m1_rdata", m1_rdata, 32'hA000_0005);
        chk("rd_m0_ack", m0_ack, 1'b0);
        chk("rd_m0_rdata", m0_rdata, 32'h0);

        // Reset mid-burst while master 1 is writing
        tick();
        m0_rd = 1'b0; m1_rd = 1'b0; m1_wr = 1'b1; m1_wdata = 32'hDEAD_BEEF;
        mid();
        chk("mid_s_wr_before", s_wr, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_m1_gnt", m1_gnt, 1'b0);
        chk("mid_rst_s_wr", s_wr, 1'b0);
        chk("mid_rst_owner", owner, 1'b1);
        tick();
        idle_inputs();
        reset = 1'b1;
        mid();
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_owner", owner, 1'b1);
        tick();

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) m0_req = ~m0_req;
            if ($urandom_range(3) == 0) m1_req = ~m1_req;
            m0_rd = 1'($urandom_range(1));
            m0_wr = 1'($urandom_range(1));
            m1_rd = 1'($urandom_range(1));
            m1_wr = 1'($urandom_range(1));
            m0_addr = 32'h4000_0000 | (32'($urandom_range(7)) << 2);
            m1_addr = 32'h4000_0000 | (32'($urandom_range(7)) << 2);
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            tick();
        end
        idle_inputs();
        tick();
        tick();
        cmp_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Two-master arbiter sharing the single memory-mapped peripheral bus (timer TH/TL/TCON, LED, digit, systick, selreg registers at 0x4000_0000–0x4000_001C) between the CPU data port (master 0) and a secondary bus master such as a DMA/loader engine (master 1). It sits between both masters and the peripheral block.

- Owns the grant state machine and the burst-length limit.
- Steers the granted master's rd/wr/addr/wdata to the slave.
- Returns slave rdata and a completion ack to the owner only.

## Interface
Parameters:
- BURST_MAX, 16: max consecutive granted cycles before forced handover when the other master is requesting; 0 = unlimited.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 requests bus ownership (held for a burst)
- m0_rd, m0_wr  in  1 each  master 0 access strobes
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_gnt  out  1  master 0 owns bus
- m0_ack  out  1  master 0 access completed this cycle
- m0_rdata  out  DATA_W  read data to master 0
- m1_req, m1_rd, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_ack, m1_rdata: same as master 0, for master 1
- s_rd, s_wr  out  1 each  strobes to peripheral
- s_addr  out  ADDR_W  address to peripheral
- s_wdata  out  DATA_W  write data to peripheral
- s_rdata  in  DATA_W  combinational read data from peripheral
- owner  out  1  last/current owner index
- busy  out  1  a grant is active

## Operation
State machine states:
- IDLE: no grant.
- G0: master 0 granted.
- G1: master 1 granted.

Registers:
- state
- burst_cnt, width ceil(log2(BURST_MAX+1)), minimum 1
- last, index of last owner

Transitions:
- IDLE:
  - Only one req asserted → that master's grant state.
  - Both asserted → grant !last (round-robin).
  - Neither → stay in IDLE.
- Gx, owner req low:
  - Other master requesting → G(other) directly, no idle cycle.
  - Otherwise → IDLE.
- Gx, owner req high, other requesting, and BURST_MAX≠0 and burst_cnt == BURST_MAX-1 → G(other) (forced handover).
- Gx, otherwise → stay.

Counters and status:
- burst_cnt clears on every state change and increments each cycle in the same Gx state.
- burst_cnt saturates at BURST_MAX-1.
- last updates to x on entry to Gx.
- gnt outputs, busy and owner decode state only (registered).

Bus steering (combinational from state):
- In Gx: s_* = mx_* (s_rd = mx_rd & mx_req, likewise s_wr).
- In IDLE: s_rd = s_wr = 0, s_addr = s_wdata = 0.
- mx_ack = mx_gnt & mx_req & (mx_rd | mx_wr).
- mx_rdata = s_rdata when mx_gnt & mx_rd, else 0.
- Strobes from a non-granted master are ignored. No ack is given, and the master must hold them until ack.
- rd and wr both high from the owner: s_wr and s_rd both asserted; the peripheral performs the write and returns old data.

## Timing
- Reset values: state = IDLE, burst_cnt = 0, last = 1 (so master 0 wins the first tie). All gnt/ack/busy = 0, owner = 1, s_rd = s_wr = 0, s_addr = s_wdata = 0, rdata outputs 0.
- Request latency: req asserted in cycle N from IDLE → gnt in cycle N+1. The access completes (ack, write captured by the peripheral at the end of the cycle) in N+1.
- Read data is valid in the same cycle as ack.
- Handover: owner drops req in cycle N → other gnt in N+1, with the old gnt low in N+1. Never two grants at once.
- Forced handover: with BURST_MAX=16 and both requesting, the owner holds 16 cycles, then the other master gets the bus in cycle 17.
- Reset asserted mid-burst: all grants drop asynchronously and no strobe reaches the slave. After release the arbiter restarts in IDLE.
- Simultaneous owner-release and other-request: resolved as a direct handover.

## Configuration
- PERIPH_ARB_FIXED_PRIO_EN defined:
  - Ties in IDLE always go to master 0.
  - Forced handover applies only while in G1; master 0 is never preempted.
  - `last` still tracks but does not affect selection.
- Undefined: round-robin tie-break and symmetric burst limit as described above.

## Test plan
- Single master: m0_req + m0_wr, addr 0x4000_0000, wdata 0x1234 in cycle 1 → m0_gnt/m0_ack/s_wr in cycle 2, TH = 0x1234. m1_gnt stays 0.
- Tie after reset: both req in same cycle → G0 first. m0 releases → G1 next cycle with no IDLE gap. Next tie → G0 again (round-robin).
- Burst limit: BURST_MAX=4, both req held → m0_gnt exactly 4 cycles, then m1_gnt 4 cycles, alternating. Never both gnt high.
- Read path: m1 granted, m1_rd at 0x4000_0014 → m1_rdata = s_rdata (systick) with m1_ack. m0_rdata = 0, m0_ack = 0 despite m0_rd high.
- Reset mid-burst: reset low while G1 with s_wr high → s_wr and m1_gnt 0 immediately. After release, owner = 1 and state is IDLE.
- With PERIPH_ARB_FIXED_PRIO_EN, BURST_MAX=4: both req held → m0 keeps grant indefinitely. m0 release → m1 granted; m0 re-request → m1 preempted after 4 cycles.
